// File: rtl/lc3_mmio_console_if.sv
// Bus bundle between the LC-3 datapath and the keyboard/display console.
// Carries the MMIO read/write strobes, the keyboard valid/ready byte stream,
// the display valid/ready byte stream and the interrupt request outputs.
// master: datapath / environment side.  slave: console device side.
interface lc3_mmio_console_if;
  logic [15:0] mmio_addr;
  logic [15:0] mmio_wdata;
  logic        mmio_wr;
  logic        mmio_rd;
  logic [15:0] mmio_rdata;
  logic        kb_valid;
  logic [7:0]  kb_data;
  logic        kb_ready;
  logic        ds_valid;
  logic [7:0]  ds_data;
  logic        ds_ready;
  logic        irq;
  logic [2:0]  intp;
  logic [7:0]  intv;
  logic        run;

  modport master (
    output mmio_addr, mmio_wdata, mmio_wr, mmio_rd, kb_valid, kb_data, ds_ready,
    input  mmio_rdata, kb_ready, ds_valid, ds_data, irq, intp, intv, run
  );

  modport slave (
    input  mmio_addr, mmio_wdata, mmio_wr, mmio_rd, kb_valid, kb_data, ds_ready,
    output mmio_rdata, kb_ready, ds_valid, ds_data, irq, intp, intv, run
  );
endinterface

// File: rtl/lc3_mmio_console.sv
// LC-3 memory-mapped keyboard/display console: KBSR/KBDR/DSR/DDR/MCR registers plus interrupt request.
// Latency: read data combinational; register writes and FIFO push/pop visible next cycle; irq one cycle after a priority change.
// Backpressure: kb_ready drops when the keyboard FIFO is full (bytes then dropped, KOVF set); display holds ds_data until ds_ready.
// Ports: clk, rst_n (async active-low), bus (slave modport of lc3_mmio_console_if):
//   mmio_addr/mmio_wdata/mmio_wr/mmio_rd in, mmio_rdata out; kb_valid/kb_data in, kb_ready out;
//   ds_valid/ds_data out, ds_ready in; irq/intp/intv out; run out (MCR[15]).
// KB_DEPTH must be a power of two and at least 2 so the pointers wrap naturally.
module lc3_mmio_console #(
  parameter int         KB_DEPTH = 4,
  parameter logic [2:0] KB_PRIO  = 3'd4,
  parameter logic [7:0] KB_VEC   = 8'h80,
  parameter logic [2:0] DS_PRIO  = 3'd2,
  parameter logic [7:0] DS_VEC   = 8'h81
) (
  input  logic                  clk,
  input  logic                  rst_n,
  lc3_mmio_console_if.slave     bus
);

  localparam int AW = $clog2(KB_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(KB_DEPTH);

  localparam logic [15:0] ADDR_KBSR = 16'hFE00;
  localparam logic [15:0] ADDR_KBDR = 16'hFE02;
  localparam logic [15:0] ADDR_DSR  = 16'hFE04;
  localparam logic [15:0] ADDR_DDR  = 16'hFE06;
  localparam logic [15:0] ADDR_MCR  = 16'hFFFE;

  typedef enum logic {DS_IDLE, DS_SEND} ds_state_t;

  // ---------------------------------------------------------------------------
  // Address decode (full 16-bit compare)
  // ---------------------------------------------------------------------------
  logic sel_kbsr, sel_kbdr, sel_dsr, sel_ddr, sel_mcr;

  assign sel_kbsr = (bus.mmio_addr == ADDR_KBSR);
  assign sel_kbdr = (bus.mmio_addr == ADDR_KBDR);
  assign sel_dsr  = (bus.mmio_addr == ADDR_DSR);
  assign sel_ddr  = (bus.mmio_addr == ADDR_DDR);
  assign sel_mcr  = (bus.mmio_addr == ADDR_MCR);

  // ---------------------------------------------------------------------------
  // Keyboard FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]    kb_mem [KB_DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] kb_cnt;
  logic          kb_full;
  logic          kb_nempty;
  logic          kb_push;
  logic          kb_pop;
  logic [7:0]    kb_head;

  assign kb_full   = (kb_cnt == FULL_CNT);
  assign kb_nempty = (kb_cnt != '0);
  // Full-ness is judged on the current count, so a pop this cycle does not
  // open a slot for a push in the same cycle.
  assign kb_push   = bus.kb_valid && !kb_full;
  // A byte arriving into an empty FIFO is not yet visible, so a KBDR read in
  // that cycle sees an empty FIFO and must not pop.
  assign kb_pop    = bus.mmio_rd && sel_kbdr && kb_nempty;
  assign kb_head   = kb_mem[rd_ptr];

  // Storage needs no reset; the count alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (kb_push) begin
      kb_mem[wr_ptr] <= bus.kb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      kb_cnt <= '0;
    end else begin
      if (kb_push) wr_ptr <= wr_ptr + AW'(1);
      if (kb_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({kb_push, kb_pop})
        2'b10:   kb_cnt <= kb_cnt + CW'(1);
        2'b01:   kb_cnt <= kb_cnt - CW'(1);
        default: kb_cnt <= kb_cnt;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Keyboard status and machine control
  // ---------------------------------------------------------------------------
  logic kie;
  logic kovf;
  logic run_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kie   <= 1'b0;
      kovf  <= 1'b0;
      run_q <= 1'b1;
    end else begin
      if (bus.mmio_wr && sel_kbsr) begin
        kie <= bus.mmio_wdata[14];
        if (bus.mmio_wdata[13]) kovf <= 1'b0;
      end
      // A fresh overflow beats a simultaneous clear so no drop goes unreported.
      if (bus.kb_valid && kb_full) kovf <= 1'b1;
      if (bus.mmio_wr && sel_mcr) run_q <= bus.mmio_wdata[15];
    end
  end

  // ---------------------------------------------------------------------------
  // Display FSM with registered handshake outputs and DSR control bits
  // ---------------------------------------------------------------------------
  ds_state_t ds_state;
  logic      ds_valid_q;
  logic [7:0] ds_data_q;
  logic      die;
  logic      dovf;
  logic      drdy;

  assign drdy = (ds_state == DS_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ds_state   <= DS_IDLE;
      ds_valid_q <= 1'b0;
      ds_data_q  <= 8'h00;
      die        <= 1'b0;
      dovf       <= 1'b0;
    end else begin
      if (bus.mmio_wr && sel_dsr) begin
        die <= bus.mmio_wdata[14];
        if (bus.mmio_wdata[13]) dovf <= 1'b0;
      end
      case (ds_state)
        DS_IDLE: begin
          if (bus.mmio_wr && sel_ddr) begin
            ds_data_q  <= bus.mmio_wdata[7:0];
            ds_valid_q <= 1'b1;
            ds_state   <= DS_SEND;
          end
        end
        DS_SEND: begin
          // ds_data is frozen while the byte is on offer; late writes are lost.
          if (bus.mmio_wr && sel_ddr) dovf <= 1'b1;
          if (bus.ds_ready) begin
            ds_valid_q <= 1'b0;
            ds_state   <= DS_IDLE;
          end
        end
        default: begin
          ds_valid_q <= 1'b0;
          ds_state   <= DS_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Interrupt request: keyboard outranks display
  // ---------------------------------------------------------------------------
  logic [2:0] tgt_p;
  logic [7:0] tgt_v;
  logic       irq_q;
  logic [2:0] intp_q;
  logic [7:0] intv_q;

  always_comb begin
    tgt_p = 3'd0;
    tgt_v = 8'h00;
    if (kie && kb_nempty) begin
      tgt_p = KB_PRIO;
      tgt_v = KB_VEC;
    end else if (die && drdy) begin
      tgt_p = DS_PRIO;
      tgt_v = DS_VEC;
    end
  end

  // The datapath re-latches INTP on every irq, so a drop to priority 0 is
  // signalled the same way as a rise, which withdraws the request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_q  <= 1'b0;
      intp_q <= 3'd0;
      intv_q <= 8'h00;
    end else begin
      irq_q <= 1'b0;
      if (tgt_p != intp_q) begin
        irq_q  <= 1'b1;
        intp_q <= tgt_p;
        intv_q <= tgt_v;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read mux (combinational, same cycle as the strobe)
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.mmio_rdata = 16'h0000;
    case (bus.mmio_addr)
      ADDR_KBSR: bus.mmio_rdata = {kb_nempty, kie, kovf, 13'h0000};
      ADDR_KBDR: bus.mmio_rdata = kb_nempty ? {8'h00, kb_head} : 16'h0000;
      ADDR_DSR:  bus.mmio_rdata = {drdy, die, dovf, 13'h0000};
      ADDR_DDR:  bus.mmio_rdata = {8'h00, ds_data_q};
      ADDR_MCR:  bus.mmio_rdata = {run_q, 15'h0000};
      default:   bus.mmio_rdata = 16'h0000;
    endcase
  end

  assign bus.kb_ready = !kb_full;
  assign bus.ds_valid = ds_valid_q;
  assign bus.ds_data  = ds_data_q;
  assign bus.irq      = irq_q;
  assign bus.intp     = intp_q;
  assign bus.intv     = intv_q;
  assign bus.run      = run_q;

endmodule

// File: tb/tb_lc3_mmio_console.sv
// Testbench for lc3_mmio_console: directed scenarios plus a randomized run against a queue-based model.
// Inputs change 1 time unit after the rising edge; outputs are sampled 3 units after it.
// Ports exercised through the lc3_mmio_console_if instance; clock period 10.
module tb_lc3_mmio_console;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  lc3_mmio_console_if bus();

  lc3_mmio_console #(
    .KB_DEPTH(DEPTH), .KB_PRIO(3'd4), .KB_VEC(8'h80), .DS_PRIO(3'd2), .DS_VEC(8'h81)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.mmio_addr = 16'h0000; bus.mmio_wdata = 16'h0000;
    bus.mmio_wr = 1'b0; bus.mmio_rd = 1'b0;
    bus.kb_valid = 1'b0; bus.kb_data = 8'h00; bus.ds_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic rd(input logic [15:0] a, output logic [15:0] d);
    bus.mmio_addr = a; bus.mmio_rd = 1'b1;
    #2 d = bus.mmio_rdata;
    tick();
    bus.mmio_rd = 1'b0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    bus.mmio_addr = a; bus.mmio_wdata = d; bus.mmio_wr = 1'b1;
    tick();
    bus.mmio_wr = 1'b0;
  endtask

  task automatic push(input logic [7:0] b);
    bus.kb_valid = 1'b1; bus.kb_data = b;
    tick();
    bus.kb_valid = 1'b0;
  endtask

  // ---------------- directed scenarios ----------------
  task automatic test_reset();
    logic [15:0] v;
    n_cmp++; if (bus.kb_ready !== 1'b1) begin n_bad++; $display("FAIL reset_kb_ready: got %b expected 1", bus.kb_ready); end
    n_cmp++; if (bus.run !== 1'b1) begin n_bad++; $display("FAIL reset_run: got %b expected 1", bus.run); end
    n_cmp++; if (bus.ds_valid !== 1'b0 || bus.ds_data !== 8'h00) begin n_bad++; $display("FAIL reset_ds: got valid=%b data=%h expected 0/00", bus.ds_valid, bus.ds_data); end
    n_cmp++; if (bus.irq !== 1'b0 || bus.intp !== 3'd0 || bus.intv !== 8'h00) begin n_bad++; $display("FAIL reset_int: got irq=%b intp=%0d intv=%h expected 0/0/00", bus.irq, bus.intp, bus.intv); end
    rd(16'hFE00, v);
    n_cmp++; if (v !== 16'h0000) begin n_bad++; $display("FAIL reset_kbsr: got %h expected 0000", v); end
    rd(16'hFE04, v);
    n_cmp++; if (v !== 16'h8000) begin n_bad++; $display("FAIL reset_dsr: got %h expected 8000", v); end
    rd(16'hFFFE, v);
    n_cmp++; if (v !== 16'h8000) begin n_bad++; $display("FAIL reset_mcr: got %h expected 8000", v); end
    rd(16'h1234, v);
    n_cmp++; if (v !== 16'h0000) begin n_bad++; $display("FAIL unmapped_read: got %h expected 0000", v); end
  endtask

  task automatic test_kb_fifo();
    logic [15:0] v;
    push(8'h41);
    rd(16'hFE00, v);
    n_cmp++; if (v !== 16'h8000) begin n_bad++; $display("FAIL kb_one_cycle_status: got %h expected 8000", v); end
    push(8'h42);
    rd(16'hFE02, v);
    n_cmp++; if (v !== 16'h0041) begin n_bad++; $display("FAIL kbdr_first: got %h expected 0041", v); end
    rd(16'hFE02, v);
    n_cmp++; if (v !== 16'h0042) begin n_bad++; $display("FAIL kbdr_second: got %h expected 0042", v); end
    rd(16'hFE00, v);
    n_cmp++; if (v !== 16'h0000) begin n_bad++; $display("FAIL kbsr_drained: got %h expected 0000", v); end
    rd(16'hFE02, v);
    n_cmp++; if (v !== 16'h0000) begin n_bad++; $display("FAIL kbdr_empty: got %h expected 0000", v); end
  endtask

  task automatic test_kb_overflow();
    logic [15:0] v;
    for (int i = 1; i <= 5; i++) push(8'(i));
    n_cmp++; if (bus.kb_ready !== 1'b0) begin n_bad++; $display("FAIL kb_full_ready: got %b expected 0", bus.kb_ready); end
    rd(16'hFE00, v);
    n_cmp++; if (v !== 16'hA000) begin n_bad++; $display("FAIL kbsr_ovf: got %h expected a000", v); end
    wr(16'hFE00, 16'h2000);
    rd(16'hFE00, v);
    n_cmp++; if (v !== 16'h8000) begin n_bad++; $display("FAIL kovf_clear: got %h expected 8000", v); end
    for (int i = 1; i <= DEPTH; i++) begin
      rd(16'hFE02, v);
      n_cmp++; if (v !== 16'(i)) begin n_bad++; $display("FAIL kb_drain_%0d: got %h expected %h", i, v, 16'(i)); end
    end
    rd(16'hFE00, v);
    n_cmp++; if (v !== 16'h0000) begin n_bad++; $display("FAIL kbsr_after_drain: got %h expected 0000", v); end
  endtask

  task automatic test_display();
    logic [15:0] v;
    bus.ds_ready = 1'b0;
    wr(16'hFE06, 16'h0058);
    n_cmp++; if (bus.ds_valid !== 1'b1) begin n_bad++; $display("FAIL ds_valid_latency: got %b expected 1", bus.ds_valid); end
    for (int i = 0; i < 3; i++) begin
      rd(16'hFE04, v);
      n_cmp++; if (v[15] !== 1'b0 || bus.ds_valid !== 1'b1 || bus.ds_data !== 8'h58) begin n_bad++; $display("FAIL ds_hold_%0d: got dsr=%h valid=%b data=%h expected dsr15=0 valid=1 data=58", i, v, bus.ds_valid, bus.ds_data); end
    end
    rd(16'hFE06, v);
    n_cmp++; if (v !== 16'h0058) begin n_bad++; $display("FAIL ddr_read: got %h expected 0058", v); end
    wr(16'hFE06, 16'h0077);
    rd(16'hFE04, v);
    n_cmp++; if (v !== 16'h2000 || bus.ds_data !== 8'h58) begin n_bad++; $display("FAIL dovf_set: got dsr=%h data=%h expected 2000/58", v, bus.ds_data); end
    bus.ds_ready = 1'b1;
    tick();
    bus.ds_ready = 1'b0;
    rd(16'hFE04, v);
    n_cmp++; if (v !== 16'hA000 || bus.ds_valid !== 1'b0) begin n_bad++; $display("FAIL drdy_return: got dsr=%h valid=%b expected a000/0", v, bus.ds_valid); end
    wr(16'hFE04, 16'h2000);
    rd(16'hFE04, v);
    n_cmp++; if (v !== 16'h8000) begin n_bad++; $display("FAIL dovf_clear: got %h expected 8000", v); end
  endtask

  task automatic test_interrupts();
    logic [15:0] v;
    wr(16'hFE00, 16'h4000);
    n_cmp++; if (bus.irq !== 1'b0 || bus.intp !== 3'd0) begin n_bad++; $display("FAIL kie_no_data: got irq=%b intp=%0d expected 0/0", bus.irq, bus.intp); end
    wr(16'hFE04, 16'h4000);
    n_cmp++; if (bus.irq !== 1'b0) begin n_bad++; $display("FAIL die_early: got irq=%b expected 0", bus.irq); end
    tick();
    n_cmp++; if (bus.irq !== 1'b1 || bus.intp !== 3'd2 || bus.intv !== 8'h81) begin n_bad++; $display("FAIL irq_display: got irq=%b intp=%0d intv=%h expected 1/2/81", bus.irq, bus.intp, bus.intv); end
    tick();
    n_cmp++; if (bus.irq !== 1'b0 || bus.intp !== 3'd2) begin n_bad++; $display("FAIL irq_pulse_width: got irq=%b intp=%0d expected 0/2", bus.irq, bus.intp); end
    push(8'h33);
    n_cmp++; if (bus.irq !== 1'b0) begin n_bad++; $display("FAIL kb_irq_early: got irq=%b expected 0", bus.irq); end
    tick();
    n_cmp++; if (bus.irq !== 1'b1 || bus.intp !== 3'd4 || bus.intv !== 8'h80) begin n_bad++; $display("FAIL irq_keyboard: got irq=%b intp=%0d intv=%h expected 1/4/80", bus.irq, bus.intp, bus.intv); end
    rd(16'hFE02, v);
    tick();
    n_cmp++; if (bus.irq !== 1'b1 || bus.intp !== 3'd2 || bus.intv !== 8'h81) begin n_bad++; $display("FAIL irq_after_pop: got irq=%b intp=%0d intv=%h expected 1/2/81", bus.irq, bus.intp, bus.intv); end
    wr(16'hFE04, 16'h0000);
    tick();
    n_cmp++; if (bus.irq !== 1'b1 || bus.intp !== 3'd0 || bus.intv !== 8'h00) begin n_bad++; $display("FAIL irq_withdraw: got irq=%b intp=%0d intv=%h expected 1/0/00", bus.irq, bus.intp, bus.intv); end
    wr(16'hFE00, 16'h0000);
  endtask

  task automatic test_reset_midflight();
    wr(16'hFE00, 16'h4000);
    for (int i = 0; i < DEPTH; i++) push(8'(8'hA0 + i));
    wr(16'hFE06, 16'h0033);
    tick();
    n_cmp++; if (bus.ds_valid !== 1'b1 || bus.kb_ready !== 1'b0 || bus.intp !== 3'd4) begin n_bad++; $display("FAIL midreset_setup: got valid=%b ready=%b intp=%0d expected 1/0/4", bus.ds_valid, bus.kb_ready, bus.intp); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.ds_valid !== 1'b0 || bus.kb_ready !== 1'b1 || bus.intp !== 3'd0 || bus.irq !== 1'b0) begin n_bad++; $display("FAIL midreset_immediate: got valid=%b ready=%b intp=%0d irq=%b expected 0/1/0/0", bus.ds_valid, bus.kb_ready, bus.intp, bus.irq); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++; if (bus.irq !== 1'b0 || bus.intp !== 3'd0) begin n_bad++; $display("FAIL midreset_no_irq_%0d: got irq=%b intp=%0d expected 0/0", i, bus.irq, bus.intp); end
    end
  endtask

  // ---------------- randomized run against a behavioural model ----------------
  logic [7:0] m_q[$];
  bit         m_kie, m_kovf, m_die, m_dovf, m_send, m_run, m_irq;
  logic [7:0] m_dsd, m_intv;
  logic [2:0] m_intp;

  function automatic logic [15:0] model_read(input logic [15:0] a);
    case (a)
      16'hFE00: return {m_q.size() > 0, m_kie, m_kovf, 13'h0};
      16'hFE02: return (m_q.size() > 0) ? {8'h00, m_q[0]} : 16'h0000;
      16'hFE04: return {!m_send, m_die, m_dovf, 13'h0};
      16'hFE06: return {8'h00, m_dsd};
      16'hFFFE: return {m_run, 15'h0};
      default:  return 16'h0000;
    endcase
  endfunction

  task automatic test_random();
    logic [15:0] addrs [6];
    logic [15:0] a, wd, exp_rd;
    logic [7:0]  kd, tv;
    logic [2:0]  tp;
    bit          kv, dr, do_rd, do_wr, old_send;
    int          op, sz;
    addrs[0] = 16'hFE00; addrs[1] = 16'hFE02; addrs[2] = 16'hFE04;
    addrs[3] = 16'hFE06; addrs[4] = 16'hFFFE; addrs[5] = 16'h3000;
    do_reset();
    m_q.delete();
    m_kie = 0; m_kovf = 0; m_die = 0; m_dovf = 0; m_send = 0; m_run = 1; m_irq = 0;
    m_dsd = 8'h00; m_intv = 8'h00; m_intp = 3'd0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      kv = ($urandom_range(0, 2) == 0);
      kd = 8'($urandom);
      dr = ($urandom_range(0, 3) == 0);
      op = $urandom_range(0, 3);
      do_rd = (op == 1 || op == 3);
      do_wr = (op == 2);
      a = ($urandom_range(0, 7) == 0) ? 16'($urandom) : addrs[$urandom_range(0, 5)];
      wd = 16'($urandom);
      bus.kb_valid = kv; bus.kb_data = kd; bus.ds_ready = dr;
      bus.mmio_rd = do_rd; bus.mmio_wr = do_wr; bus.mmio_addr = a; bus.mmio_wdata = wd;
      #2;
      exp_rd = model_read(a);
      if (do_rd) begin
        n_cmp++; if (bus.mmio_rdata !== exp_rd) begin n_bad++; $display("FAIL rand_read cyc=%0d addr=%h: got %h expected %h", cyc, a, bus.mmio_rdata, exp_rd); end
      end
      n_cmp++;
      if (bus.kb_ready !== (m_q.size() < DEPTH) || bus.ds_valid !== m_send || bus.ds_data !== m_dsd || bus.run !== m_run) begin
        n_bad++; $display("FAIL rand_outputs cyc=%0d: got ready=%b valid=%b data=%h run=%b expected %b/%b/%h/%b",
                          cyc, bus.kb_ready, bus.ds_valid, bus.ds_data, bus.run, m_q.size() < DEPTH, m_send, m_dsd, m_run);
      end
      n_cmp++;
      if (bus.irq !== m_irq || bus.intp !== m_intp || bus.intv !== m_intv) begin
        n_bad++; $display("FAIL rand_irq cyc=%0d: got irq=%b intp=%0d intv=%h expected %b/%0d/%h", cyc, bus.irq, bus.intp, bus.intv, m_irq, m_intp, m_intv);
      end
      // interrupt target from the state seen this cycle
      tp = 3'd0; tv = 8'h00;
      if (m_kie && m_q.size() > 0) begin tp = 3'd4; tv = 8'h80; end
      else if (m_die && !m_send) begin tp = 3'd2; tv = 8'h81; end
      m_irq = (tp != m_intp);
      if (m_irq) begin m_intp = tp; m_intv = tv; end
      // keyboard side
      sz = m_q.size();
      if (do_wr && a == 16'hFE00) begin m_kie = wd[14]; if (wd[13]) m_kovf = 0; end
      if (kv && sz == DEPTH) m_kovf = 1;
      if (do_rd && a == 16'hFE02 && sz > 0) void'(m_q.pop_front());
      if (kv && sz < DEPTH) m_q.push_back(kd);
      // display side
      old_send = m_send;
      if (do_wr && a == 16'hFE04) begin m_die = wd[14]; if (wd[13]) m_dovf = 0; end
      if (do_wr && a == 16'hFE06) begin
        if (!old_send) begin m_dsd = wd[7:0]; m_send = 1; end
        else m_dovf = 1;
      end
      if (old_send && dr) m_send = 0;
      if (do_wr && a == 16'hFFFE) m_run = wd[15];
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    do_reset();
    test_reset();
    test_kb_fifo();
    test_kb_overflow();
    test_display();
    test_interrupts();
    test_reset_midflight();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lc3_mmio_console.md
# lc3_mmio_console

Memory-mapped keyboard/display device controller that answers the LC-3 datapath's I/O window (addresses x FE00 and up). It decodes the MAR address, serves reads and writes of the KBSR/KBDR/DSR/DDR/MCR registers, and buffers incoming keyboard bytes in a small FIFO. It drives the outgoing display byte through a valid/ready handshake. It raises the datapath's IRQ/INTP/INTV interrupt inputs when an enabled device becomes ready.

## Interface
Parameters:
- KB_DEPTH, 4: keyboard FIFO entries; must be a power of two and at least 2.
- KB_PRIO, 3'd4: interrupt priority for the keyboard.
- KB_VEC, 8'h80: interrupt vector for the keyboard.
- DS_PRIO, 3'd2: interrupt priority for the display.
- DS_VEC, 8'h81: interrupt vector for the display.

Ports:
- clk  in  1: single clock; everything is rising-edge.
- rst_n  in  1: asynchronous, active-low reset.
- mmio_addr  in  16: MAR value from the datapath.
- mmio_wdata  in  16: MDR value, used for writes.
- mmio_wr  in  1: write strobe; one cycle = one write.
- mmio_rd  in  1: read strobe; one cycle = one read.
- mmio_rdata  out  16: combinational read data.
- kb_valid  in  1: keyboard byte offered.
- kb_data  in  8: keyboard byte.
- kb_ready  out  1: FIFO not full.
- ds_valid  out  1: display byte offered.
- ds_data  out  8: display byte.
- ds_ready  in  1: display accepts the byte.
- irq  out  1: one-cycle interrupt-priority update strobe.
- intp  out  3: pending priority; 0 means none.
- intv  out  8: pending vector.
- run  out  1: MCR[15], machine run enable.

## Operation
- Address decode covers the full 16-bit address. Any address outside the map below reads 16'h0000 and ignores writes.
  - x FE00 is KBSR: bit 15 = FIFO non-empty (read-only); bit 14 = KIE (R/W); bit 13 = KOVF (sticky). A write with mmio_wdata[13]=1 clears KOVF.
  - x FE02 is KBDR: reads {8'h00, FIFO head}. The read pops the head at the clock edge. A read while empty returns 16'h0000 and does not pop. Writes are ignored.
  - x FE04 is DSR: bit 15 = DRDY (display FSM in IDLE); bit 14 = DIE (R/W); bit 13 = DOVF (sticky, write 1 to clear).
  - x FE06 is DDR: a write in IDLE latches mmio_wdata[7:0] into ds_data and enters SEND. A write in SEND is dropped and sets DOVF. Reads return {8'h00, ds_data}.
  - x FFFE is MCR: bit 15 is R/W and drives run. All other bits read 0.
- Keyboard FIFO:
  - Read and write pointers are log2(KB_DEPTH) bits and wrap modulo KB_DEPTH. The count ranges 0..KB_DEPTH.
  - A push happens when kb_valid && kb_ready. kb_ready = (count != KB_DEPTH), evaluated before any pop in the same cycle.
  - When the FIFO is full, kb_valid sets KOVF and the byte is dropped.
  - A push and pop in the same cycle leaves count unchanged. Pushing into an empty FIFO while a read happens in the same cycle is not a pop: the read returns 0.
- Display FSM has two states, IDLE and SEND.
  - SEND: ds_valid=1 and ds_data is held stable. On ds_ready the FSM returns to IDLE.
  - IDLE: ds_valid=0.
- Interrupt logic:
  - kb_int = KIE && non-empty.
  - ds_int = DIE && DRDY.
  - Target priority/vector is the keyboard's if kb_int, else the display's if ds_int, else 0/8'h00. The keyboard wins ties.
  - Whenever the target priority differs from the registered intp, the next cycle registers the new intp/intv and pulses irq for exactly one cycle.
  - Sending intp=0 on irq withdraws the request, because the datapath latches INTP on every IRQ.
- Status bits 12:0 of KBSR/DSR read 0, except bit 13.

## Timing
- Reset values: kb_ready=1, FIFO empty, KIE=0, KOVF=0, DIE=0, DOVF=0, display FSM in IDLE, ds_valid=0, ds_data=8'h00, irq=0, intp=3'd0, intv=8'h00, MCR=16'h8000 (so run=1).
- mmio_rdata is combinational from mmio_addr and the current state, valid in the same cycle as mmio_rd.
- Register writes take effect at the strobe's clock edge and are visible on the next cycle.
- kb_valid to KBSR[15]=1 takes one cycle. With KIE set, irq pulses 2 cycles after kb_valid.
- DDR write to ds_valid=1 takes one cycle. ds_ready to DRDY=1 takes one cycle.
- Priority changes on back-to-back cycles produce back-to-back irq pulses, each carrying the latest value.
- rst_n asserted mid-transfer forces reset values immediately. The FIFO contents are lost, ds_valid drops, and no irq is emitted.

## Test plan
- Reset, then read x FE00, FE04, FFFE → expect 16'h0000, 16'h8000, 16'h8000. kb_ready=1, run=1.
- Push bytes 0x41, 0x42 → KBSR reads 16'h8000. KBDR reads return 16'h0041 then 16'h0042. KBSR then reads 16'h0000.
- Push 5 bytes with KB_DEPTH=4 → the 5th byte is dropped and KBSR reads 16'hA000. Write KBSR with 16'h2000 → KBSR reads 16'h8000.
- Write DDR 16'h0058 with ds_ready=0 for 3 cycles → ds_valid=1, ds_data=8'h58, DSR[15]=0. A second DDR write sets DOVF. Raise ds_ready → DSR[15]=1 one cycle later.
- Set KIE and DIE with the display IDLE → irq pulse with intp=2, intv=8'h81. Push a byte → irq with intp=4, intv=8'h80. Pop → irq with intp=2. Clear DIE → irq with intp=0.
- Assert rst_n low while in SEND with a full FIFO → ds_valid=0, kb_ready=1, intp=0 immediately. No irq follows the release of reset.
